// File: rtl/rv32i_types.sv
// Shared load/store encodings: RISC-V funct3 size codes, the access-size enum
// and the handshake FSM states used by the memory access unit.
package rv32i_types;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    MEM_B  = F3_B,
    MEM_H  = F3_H,
    MEM_W  = F3_W,
    MEM_D  = F3_D,
    MEM_BU = F3_BU,
    MEM_HU = F3_HU,
    MEM_WU = F3_WU
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mau_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store-side byte mask, data shift and legality check,
// plus load-side extraction and sign/zero extension from the cache word.
module mem_align
  import rv32i_types::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(NB)
) (
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [OFF_W-1:0]      req_off_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic [NB-1:0]         st_mbe_o,
  output logic [DATA_WIDTH-1:0] st_wdata_o,
  output logic                  req_fault_o,
  input  logic [2:0]            ld_funct3_i,
  input  logic [OFF_W-1:0]      ld_off_i,
  input  logic [DATA_WIDTH-1:0] ld_rdata_i,
  output logic [DATA_WIDTH-1:0] ld_data_o
);

  mem_size_t             req_size;
  mem_size_t             ld_size;
  logic [NB-1:0]         size_mask;
  logic                  illegal;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] ld_shift;

  assign req_size = mem_size_t'(req_funct3_i);
  assign ld_size  = mem_size_t'(ld_funct3_i);

  // D and WU exist only on the 64-bit datapath; stores have no unsigned forms.
  always_comb begin
    size_mask  = '0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (req_size)
      MEM_B, MEM_BU: size_mask = NB'(1);
      MEM_H, MEM_HU: begin
        size_mask  = NB'(3);
        misaligned = req_off_i[0];
      end
      MEM_W: begin
        size_mask  = NB'(15);
        misaligned = |req_off_i[1:0];
      end
      MEM_WU: begin
        size_mask  = NB'(15);
        misaligned = |req_off_i[1:0];
        illegal    = (DATA_WIDTH != 64);
      end
      MEM_D: begin
        size_mask  = '1;
        misaligned = |req_off_i;
        illegal    = (DATA_WIDTH != 64);
      end
      default: illegal = 1'b1;
    endcase
    if (is_store_i && req_funct3_i[2]) illegal = 1'b1;
  end

  assign req_fault_o = (is_load_i && is_store_i) || illegal || misaligned;
  assign st_mbe_o    = size_mask << req_off_i;
  assign st_wdata_o  = req_wdata_i << {req_off_i, 3'b000};

  assign ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_shift;
    case (ld_size)
      MEM_B:   ld_data_o = DATA_WIDTH'($signed(ld_shift[7:0]));
      MEM_BU:  ld_data_o = DATA_WIDTH'(ld_shift[7:0]);
      MEM_H:   ld_data_o = DATA_WIDTH'($signed(ld_shift[15:0]));
      MEM_HU:  ld_data_o = DATA_WIDTH'(ld_shift[15:0]);
      MEM_W:   ld_data_o = DATA_WIDTH'($signed(ld_shift[31:0]));
      MEM_WU:  ld_data_o = DATA_WIDTH'(ld_shift[31:0]);
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Registered load/store unit: accepts one EX/MEM operation at a time, holds the
// cache request until data_resp and returns a one-cycle write-back strobe.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int TAG_WIDTH  = 8,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic                  ex_load_i,
  input  logic                  ex_store_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic [TAG_WIDTH-1:0]  ex_tag_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [NB-1:0]         data_mbe_o,
  output logic                  data_read_o,
  output logic                  data_write_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  input  logic                  data_resp_i,
  output logic                  wb_valid_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [TAG_WIDTH-1:0]  wb_tag_o,
  output logic                  wb_fault_o
);

  mau_state_t            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         mbe_q;
  logic                  read_q;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [OFF_W-1:0]      off_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  wb_valid_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [TAG_WIDTH-1:0]  wb_tag_q;
  logic                  wb_fault_q;

  logic                  accept;
  logic                  is_mem;
  logic [NB-1:0]         st_mbe;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic                  req_fault;
  logic [DATA_WIDTH-1:0] ld_data;

  assign ex_ready_o = (state_q == IDLE) && !rst;
  assign accept     = ex_valid_i && ex_ready_o;
  assign is_mem     = ex_load_i || ex_store_i;

  mem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .is_load_i    (ex_load_i),
    .is_store_i   (ex_store_i),
    .req_funct3_i (ex_funct3_i),
    .req_off_i    (ex_addr_i[OFF_W-1:0]),
    .req_wdata_i  (ex_wdata_i),
    .st_mbe_o     (st_mbe),
    .st_wdata_o   (st_wdata),
    .req_fault_o  (req_fault),
    .ld_funct3_i  (funct3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (data_rdata_i),
    .ld_data_o    (ld_data)
  );

  // Request registers feed the cache port directly, so reset drops them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      mbe_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      tag_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= DATA_WIDTH'(ex_addr_i);
              wb_fault_q <= 1'b0;
              wb_tag_q   <= ex_tag_i;
            end else if (req_fault) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= '0;
              wb_fault_q <= 1'b1;
              wb_tag_q   <= ex_tag_i;
            end else begin
              addr_q   <= {ex_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              wdata_q  <= st_wdata;
              mbe_q    <= st_mbe;
              read_q   <= ex_load_i;
              write_q  <= ex_store_i;
              funct3_q <= ex_funct3_i;
              off_q    <= ex_addr_i[OFF_W-1:0];
              tag_q    <= ex_tag_i;
              state_q  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (data_resp_i) begin
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_data_q  <= read_q ? ld_data : '0;
            wb_fault_q <= 1'b0;
            wb_tag_q   <= tag_q;
            state_q    <= IDLE;
          end
        end
      endcase
    end
  end

  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign data_mbe_o   = mbe_q;
  assign data_read_o  = read_q;
  assign data_write_o = write_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_data_o    = wb_data_q;
  assign wb_tag_o     = wb_tag_q;
  assign wb_fault_o   = wb_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32- and 64-bit instances driven by directed and
// random operations, checked against an arithmetic reference of the lane rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  int          curDw;
  logic        exValid;
  logic        exLoad;
  logic        exStore;
  logic [2:0]  exFunct3;
  logic [31:0] exAddr;
  logic [63:0] exWdata;
  logic [7:0]  exTag;
  logic [63:0] dataRdata;
  logic        dataResp;

  logic        r32Ready, r32Read, r32Write, r32WbValid, r32WbFault;
  logic [31:0] r32Addr, r32Wdata, r32WbData;
  logic [3:0]  r32Mbe;
  logic [7:0]  r32WbTag;
  logic        r64Ready, r64Read, r64Write, r64WbValid, r64WbFault;
  logic [31:0] r64Addr;
  logic [63:0] r64Wdata, r64WbData;
  logic [7:0]  r64Mbe;
  logic [7:0]  r64WbTag;

  logic        obsReady, obsRead, obsWrite, obsWbValid, obsWbFault;
  logic [63:0] obsAddr, obsWdata, obsMbe, obsWbData, obsWbTag;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(8)) dut32 (
    .clk(clk), .rst(rst),
    .ex_valid_i(exValid && curDw == 32), .ex_ready_o(r32Ready),
    .ex_load_i(exLoad), .ex_store_i(exStore), .ex_funct3_i(exFunct3),
    .ex_addr_i(exAddr), .ex_wdata_i(exWdata[31:0]), .ex_tag_i(exTag),
    .data_addr_o(r32Addr), .data_wdata_o(r32Wdata), .data_mbe_o(r32Mbe),
    .data_read_o(r32Read), .data_write_o(r32Write),
    .data_rdata_i(dataRdata[31:0]), .data_resp_i(dataResp && curDw == 32),
    .wb_valid_o(r32WbValid), .wb_data_o(r32WbData), .wb_tag_o(r32WbTag),
    .wb_fault_o(r32WbFault)
  );

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TAG_WIDTH(8)) dut64 (
    .clk(clk), .rst(rst),
    .ex_valid_i(exValid && curDw == 64), .ex_ready_o(r64Ready),
    .ex_load_i(exLoad), .ex_store_i(exStore), .ex_funct3_i(exFunct3),
    .ex_addr_i(exAddr), .ex_wdata_i(exWdata), .ex_tag_i(exTag),
    .data_addr_o(r64Addr), .data_wdata_o(r64Wdata), .data_mbe_o(r64Mbe),
    .data_read_o(r64Read), .data_write_o(r64Write),
    .data_rdata_i(dataRdata), .data_resp_i(dataResp && curDw == 64),
    .wb_valid_o(r64WbValid), .wb_data_o(r64WbData), .wb_tag_o(r64WbTag),
    .wb_fault_o(r64WbFault)
  );

  always_comb begin
    if (curDw == 64) begin
      obsReady = r64Ready;   obsRead = r64Read;   obsWrite = r64Write;
      obsWbValid = r64WbValid; obsWbFault = r64WbFault;
      obsAddr = {32'h0, r64Addr}; obsWdata = r64Wdata; obsMbe = {56'h0, r64Mbe};
      obsWbData = r64WbData; obsWbTag = {56'h0, r64WbTag};
    end else begin
      obsReady = r32Ready;   obsRead = r32Read;   obsWrite = r32Write;
      obsWbValid = r32WbValid; obsWbFault = r32WbFault;
      obsAddr = {32'h0, r32Addr}; obsWdata = {32'h0, r32Wdata}; obsMbe = {60'h0, r32Mbe};
      obsWbData = {32'h0, r32WbData}; obsWbTag = {56'h0, r32WbTag};
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
  endtask

  // kind: 0 = non-memory, 1 = fault, 2 = legal cache access
  function automatic void refModel(input int dw, input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [63:0] wdata,
                                   input logic [63:0] rdata, output int kind,
                                   output logic [63:0] eAddr, output logic [63:0] eMbe,
                                   output logic [63:0] eWdata, output logic [63:0] eLoad);
    longint unsigned dwMask, nbytes, off, fmask, v;
    bit legal;
    dwMask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    nbytes = 64'd1 << f3[1:0];
    off    = 64'(addr) % 64'(dw / 8);
    legal  = (f3 != 3'd7) && !(st && f3 > 3'd3) && !(dw == 32 && (f3 == 3'd3 || f3 == 3'd6));
    if (!ld && !st) kind = 0;
    else if ((ld && st) || !legal || (64'(addr) % nbytes) != 0) kind = 1;
    else kind = 2;
    eAddr  = 64'(addr) - off;
    eMbe   = ((64'd1 << nbytes) - 64'd1) << off;
    eWdata = (wdata << (8 * off)) & dwMask;
    fmask  = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * nbytes)) - 64'd1;
    v      = ((rdata & dwMask) >> (8 * off)) & fmask;
    if (!f3[2] && ((v >> (8 * nbytes - 1)) & 64'd1) == 64'd1) v = v | ~fmask;
    eLoad  = v & dwMask;
  endfunction

  task automatic applyStimulus(input int dw, input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [7:0] tag, input logic [63:0] rdata, input int delay);
    int kind;
    logic [63:0] eAddr, eMbe, eWdata, eLoad;
    refModel(dw, ld, st, f3, addr, wdata, rdata, kind, eAddr, eMbe, eWdata, eLoad);
    @(negedge clk);
    curDw = dw; exLoad = ld; exStore = st; exFunct3 = f3;
    exAddr = addr; exWdata = wdata; exTag = tag; exValid = 1'b1;
    #1 checkOutput("ready_before_accept", {63'h0, obsReady}, 64'd1);
    @(negedge clk);
    exValid = 1'b0;
    if (kind != 2) begin
      checkOutput("wb_valid_direct", {63'h0, obsWbValid}, 64'd1);
      checkOutput("wb_fault_direct", {63'h0, obsWbFault}, (kind == 1) ? 64'd1 : 64'd0);
      checkOutput("wb_data_direct", obsWbData, (kind == 0) ? 64'(addr) : 64'd0);
      checkOutput("wb_tag_direct", obsWbTag, 64'(tag));
      checkOutput("no_cache_req", {62'h0, obsRead, obsWrite}, 64'd0);
      @(negedge clk);
      checkOutput("wb_valid_pulse", {63'h0, obsWbValid}, 64'd0);
    end else begin
      checkOutput("req_read", {63'h0, obsRead}, 64'(ld));
      checkOutput("req_write", {63'h0, obsWrite}, 64'(st));
      checkOutput("req_addr", obsAddr, eAddr);
      checkOutput("req_mbe", obsMbe, eMbe);
      if (st) checkOutput("req_wdata", obsWdata, eWdata);
      checkOutput("busy_ready", {63'h0, obsReady}, 64'd0);
      repeat (delay) begin
        @(negedge clk);
        checkOutput("req_held", {62'h0, obsRead, obsWrite}, {62'h0, ld, st});
        checkOutput("req_addr_held", obsAddr, eAddr);
        checkOutput("busy_no_wb", {63'h0, obsWbValid}, 64'd0);
      end
      dataRdata = rdata; dataResp = 1'b1;
      @(negedge clk);
      dataResp = 1'b0;
      checkOutput("wb_valid_resp", {63'h0, obsWbValid}, 64'd1);
      checkOutput("wb_data_resp", obsWbData, ld ? eLoad : 64'd0);
      checkOutput("wb_tag_resp", obsWbTag, 64'(tag));
      checkOutput("wb_fault_resp", {63'h0, obsWbFault}, 64'd0);
      checkOutput("ready_on_wb", {63'h0, obsReady}, 64'd1);
      checkOutput("req_dropped", {62'h0, obsRead, obsWrite}, 64'd0);
      @(negedge clk);
      checkOutput("wb_valid_pulse", {63'h0, obsWbValid}, 64'd0);
      checkOutput("wb_data_hold", obsWbData, ld ? eLoad : 64'd0);
    end
  endtask

  initial begin
    int dw, cls;
    bit ld, st;
    logic [2:0] f3;
    logic [31:0] addr;

    rst = 1'b1; curDw = 32; exValid = 1'b0; exLoad = 1'b0; exStore = 1'b0;
    exFunct3 = 3'b000; exAddr = '0; exWdata = '0; exTag = '0; dataRdata = '0; dataResp = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready32", {63'h0, r32Ready}, 64'd0);
    checkOutput("reset_ready64", {63'h0, r64Ready}, 64'd0);
    checkOutput("reset_outputs32", {60'h0, r32Read, r32Write, r32WbValid, r32WbFault}, 64'd0);
    checkOutput("reset_wb_data64", r64WbData, 64'd0);
    rst = 1'b0;
    #1 checkOutput("ready_after_reset", {63'h0, r32Ready}, 64'd1);

    applyStimulus(32, 1'b0, 1'b1, 3'b000, 32'h1003, 64'hAB, 8'h11, 64'h0, 2);
    applyStimulus(32, 1'b1, 1'b0, 3'b001, 32'h2002, 64'h0, 8'h22, 64'h8001_1234, 0);
    applyStimulus(32, 1'b1, 1'b0, 3'b101, 32'h2002, 64'h0, 8'h23, 64'h8001_1234, 1);
    applyStimulus(32, 1'b1, 1'b0, 3'b010, 32'h2001, 64'h0, 8'h24, 64'h0, 0);
    applyStimulus(32, 1'b1, 1'b0, 3'b011, 32'h2000, 64'h0, 8'h25, 64'h0, 0);
    applyStimulus(32, 1'b0, 1'b1, 3'b100, 32'h2000, 64'h0, 8'h26, 64'h0, 0);
    applyStimulus(32, 1'b1, 1'b1, 3'b000, 32'h2000, 64'h0, 8'h27, 64'h0, 0);
    applyStimulus(32, 1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 64'h0, 8'h28, 64'h0, 0);
    applyStimulus(64, 1'b0, 1'b1, 3'b011, 32'h08, 64'h1122_3344_5566_7788, 8'h31, 64'h0, 1);
    applyStimulus(64, 1'b1, 1'b0, 3'b110, 32'h0C, 64'h0, 8'h32, 64'hF000_0001_0000_0000, 0);
    applyStimulus(64, 1'b1, 1'b0, 3'b011, 32'h14, 64'h0, 8'h33, 64'h0, 0);

    // Second op held on ex_valid while BUSY is taken in the write-back cycle.
    @(negedge clk);
    curDw = 32; exLoad = 1'b1; exStore = 1'b0; exFunct3 = 3'b010;
    exAddr = 32'h100; exTag = 8'h41; exValid = 1'b1;
    @(negedge clk);
    exLoad = 1'b0; exAddr = 32'h55; exTag = 8'h77;
    #1 checkOutput("b2b_ready_busy", {63'h0, obsReady}, 64'd0);
    checkOutput("b2b_addr_stable", obsAddr, 64'h100);
    @(negedge clk);
    checkOutput("b2b_addr_stable2", obsAddr, 64'h100);
    checkOutput("b2b_read_held", {63'h0, obsRead}, 64'd1);
    dataRdata = 64'h0000_0000_CAFE_F00D; dataResp = 1'b1;
    @(negedge clk);
    dataResp = 1'b0;
    checkOutput("b2b_wb1_valid", {63'h0, obsWbValid}, 64'd1);
    checkOutput("b2b_wb1_data", obsWbData, 64'hCAFE_F00D);
    checkOutput("b2b_wb1_tag", obsWbTag, 64'h41);
    checkOutput("b2b_ready_wb", {63'h0, obsReady}, 64'd1);
    @(negedge clk);
    exValid = 1'b0;
    checkOutput("b2b_wb2_valid", {63'h0, obsWbValid}, 64'd1);
    checkOutput("b2b_wb2_data", obsWbData, 64'h55);
    checkOutput("b2b_wb2_tag", obsWbTag, 64'h77);

    @(negedge clk);
    dataResp = 1'b1;
    @(negedge clk);
    dataResp = 1'b0;
    checkOutput("stray_resp_no_wb", {63'h0, obsWbValid}, 64'd0);
    checkOutput("stray_resp_hold", obsWbData, 64'h55);

    // Reset while a load is outstanding; a late response must not complete it.
    @(negedge clk);
    exLoad = 1'b1; exStore = 1'b0; exFunct3 = 3'b000; exAddr = 32'h40; exTag = 8'h12; exValid = 1'b1;
    @(negedge clk);
    exValid = 1'b0;
    checkOutput("rst_pre_read", {63'h0, obsRead}, 64'd1);
    rst = 1'b1;
    #1 checkOutput("rst_read_drop", {63'h0, obsRead}, 64'd0);
    checkOutput("rst_ready_low", {63'h0, obsReady}, 64'd0);
    dataResp = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_wb", {63'h0, obsWbValid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    dataResp = 1'b0;
    checkOutput("late_resp_no_wb", {63'h0, obsWbValid}, 64'd0);
    checkOutput("late_resp_idle", {63'h0, obsReady}, 64'd1);
    applyStimulus(32, 1'b1, 1'b0, 3'b000, 32'h3, 64'h0, 8'h5A, 64'h80AA_BBCC, 1);

    for (int i = 0; i < 80; i++) begin
      dw  = ($urandom_range(0, 1) == 1) ? 64 : 32;
      cls = $urandom_range(0, 9);
      ld  = (cls == 1) || (cls >= 2 && cls < 6);
      st  = (cls == 1) || (cls >= 6);
      f3  = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      applyStimulus(dw, ld, st, f3, addr, {$urandom, $urandom}, 8'($urandom),
                    {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
